// File: rtl/lsu_sram_master_if.sv
// -----------------------------------------------------------------------------
// lsu_sram_master_if
// Purpose : bundles the CPU request/response handshakes and the data SRAM port
//           used by the load/store unit.
// Signals :
//   req_valid/req_ready              CPU request handshake
//   req_funct3, req_store            RV32 access type (load/store, width, sign)
//   req_addr, req_wdata              byte address, LSB-aligned store data
//   resp_valid/resp_ready            response handshake
//   resp_rdata, resp_fault           extended load data, access-rejected flag
//   mem_w_en, mem_address,
//   mem_write_data, mem_read_data    SRAM byte-enable, address, data lines
// Modports:
//   master : the LSU (drives req_ready, resp_*, mem_* outputs)
//   slave  : the environment (CPU request/response side plus the SRAM)
// -----------------------------------------------------------------------------
interface lsu_sram_master_if #(
    parameter int unsigned ADDR_W = 16
) ();
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_funct3;
    logic              req_store;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_fault;
    logic [3:0]        mem_w_en;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    modport master (
        input  req_valid, req_funct3, req_store, req_addr, req_wdata,
        input  resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_w_en, mem_address, mem_write_data
    );

    modport slave (
        output req_valid, req_funct3, req_store, req_addr, req_wdata,
        output resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_w_en, mem_address, mem_write_data
    );
endinterface

// File: rtl/lsu_sram_master.sv
// -----------------------------------------------------------------------------
// lsu_sram_master
// Purpose : initiator side of the byte-addressed data SRAM. Accepts one CPU
//           load/store at a time, performs a single-cycle SRAM access, aligns
//           and extends load data, and returns a response. Illegal accesses
//           (bad funct3 or out of the 2^ADDR_W byte range) are reported as
//           faults and never touch memory.
// Ports   :
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - lsu_sram_master_if.master (CPU request/response + SRAM port)
// Flow    : IDLE -(accept)-> ACCESS (1 cycle) -> RESP -(resp_ready)-> IDLE
// -----------------------------------------------------------------------------
module lsu_sram_master #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    lsu_sram_master_if.master    bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            r_state;
    logic [2:0]        r_funct3;
    logic              r_store;
    logic              r_fault;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_fault;
    logic [3:0]        r_mem_w_en;
    logic [ADDR_W-1:0] r_mem_address;
    logic [31:0]       r_mem_write_data;

    logic [1:0]        w_size_m1;
    logic              w_legal;
    logic [ADDR_W:0]   w_last;
    logic              w_high;
    logic              w_fault;
    logic [3:0]        w_mask;
    logic [31:0]       w_load_data;

    // Request decode, evaluated on the live request while in IDLE.
    always_comb begin
        w_size_m1 = 2'd0;
        unique case (bus.req_funct3[1:0])
            2'b00:   w_size_m1 = 2'd0;
            2'b01:   w_size_m1 = 2'd1;
            default: w_size_m1 = 2'd3;
        endcase

        if (bus.req_store) begin
            w_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            w_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end

        // Carry out of the extra top bit means the access runs past the last byte.
        w_last  = {1'b0, bus.req_addr[ADDR_W-1:0]} + {{(ADDR_W-1){1'b0}}, w_size_m1};
        w_high  = (bus.req_addr >> ADDR_W) != 32'd0;
        w_fault = !w_legal || w_high || w_last[ADDR_W];

        w_mask = 4'b0000;
        if (bus.req_store && !w_fault) begin
            unique case (bus.req_funct3)
                3'b000:  w_mask = 4'b0001;
                3'b001:  w_mask = 4'b0011;
                3'b010:  w_mask = 4'b1111;
                default: w_mask = 4'b0000;
            endcase
        end
    end

    // Load alignment/extension from the latched op, applied at the end of ACCESS.
    always_comb begin
        w_load_data = 32'd0;
        unique case (r_funct3)
            3'b000:  w_load_data = {{24{bus.mem_read_data[7]}}, bus.mem_read_data[7:0]};
            3'b100:  w_load_data = {24'd0, bus.mem_read_data[7:0]};
            3'b001:  w_load_data = {{16{bus.mem_read_data[15]}}, bus.mem_read_data[15:0]};
            3'b101:  w_load_data = {16'd0, bus.mem_read_data[15:0]};
            3'b010:  w_load_data = bus.mem_read_data;
            default: w_load_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= StIdle;
            r_funct3         <= 3'd0;
            r_store          <= 1'b0;
            r_fault          <= 1'b0;
            r_req_ready      <= 1'b1;
            r_resp_valid     <= 1'b0;
            r_resp_rdata     <= 32'd0;
            r_resp_fault     <= 1'b0;
            r_mem_w_en       <= 4'b0000;
            r_mem_address    <= '0;
            r_mem_write_data <= 32'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_funct3         <= bus.req_funct3;
                        r_store          <= bus.req_store;
                        r_fault          <= w_fault;
                        r_mem_address    <= bus.req_addr[ADDR_W-1:0];
                        r_mem_write_data <= bus.req_wdata;
                        r_mem_w_en       <= w_mask;
                        r_req_ready      <= 1'b0;
                        r_state          <= StAccess;
                    end
                end
                StAccess: begin
                    // The SRAM commits the store on this edge; drop the mask after it.
                    r_mem_w_en   <= 4'b0000;
                    r_resp_rdata <= (r_store || r_fault) ? 32'd0 : w_load_data;
                    r_resp_fault <= r_fault;
                    r_resp_valid <= 1'b1;
                    r_state      <= StResp;
                end
                StResp: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_ready      = r_req_ready;
    assign bus.resp_valid     = r_resp_valid;
    assign bus.resp_rdata     = r_resp_rdata;
    assign bus.resp_fault     = r_resp_fault;
    assign bus.mem_w_en       = r_mem_w_en;
    assign bus.mem_address    = r_mem_address;
    assign bus.mem_write_data = r_mem_write_data;

endmodule

// File: tb/tb_lsu_sram_master.sv
// -----------------------------------------------------------------------------
// tb_lsu_sram_master
// Purpose : self-checking bench for lsu_sram_master. Contains a byte-array
//           SRAM, a directed vector table, hand sequences for backpressure and
//           mid-operation reset, and randomized traffic checked against a
//           byte-level reference model of the load/store rules.
// -----------------------------------------------------------------------------
module tb_lsu_sram_master;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned MEM_SZ = 1 << ADDR_W;

    logic clk;
    logic rst;

    lsu_sram_master_if #(.ADDR_W(ADDR_W)) bus ();

    lsu_sram_master #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: combinational read, byte-masked write at the rising edge.
    logic [7:0]        mem [0:MEM_SZ-1];
    logic [ADDR_W-1:0] ra;

    always_comb begin
        ra = bus.mem_address;
        bus.mem_read_data = {mem[ra + 16'd3], mem[ra + 16'd2], mem[ra + 16'd1], mem[ra]};
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_w_en[i]) begin
                mem[16'(bus.mem_address + 16'(i))] <= bus.mem_write_data[8*i +: 8];
            end
        end
    end

    initial begin
        for (int i = 0; i < MEM_SZ; i++) mem[i] <= 8'h00;
    end

    // Reference model state.
    logic [7:0] ref_mem [0:MEM_SZ-1];

    int n_vec;
    int n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Spec-level model: size, legality and range by plain arithmetic.
    task automatic ref_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic fault, output logic [3:0] wen);
        int         size;
        bit         legal;
        longint     last;
        logic [31:0] w;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            default:    size = 4;
        endcase
        if (st) legal = (f3 <= 3'd2);
        else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        last  = longint'(addr) + longint'(size) - 1;
        fault = !legal || (last > longint'(MEM_SZ - 1));
        rdata = 32'd0;
        wen   = 4'b0000;
        if (!fault) begin
            if (st) begin
                wen = (size == 1) ? 4'b0001 : (size == 2) ? 4'b0011 : 4'b1111;
                for (int b = 0; b < size; b++) ref_mem[16'(addr[15:0] + 16'(b))] = wdata[8*b +: 8];
            end else begin
                for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_mem[16'(addr[15:0] + 16'(b))];
                case (f3)
                    3'd0:    rdata = 32'($signed(w[7:0]));
                    3'd4:    rdata = 32'(w[7:0]);
                    3'd1:    rdata = 32'($signed(w[15:0]));
                    3'd5:    rdata = 32'(w[15:0]);
                    default: rdata = w;
                endcase
            end
        end
    endtask

    // Full transaction, entered and left 1 time unit after a rising edge in IDLE.
    task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_fault, input logic [3:0] exp_wen, input int stall);
        int cnt;
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.resp_ready = (stall == 0);
        cnt = 0;
        while (!bus.req_ready && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (cnt >= 20) chk("accept_timeout", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("access_wen", {28'd0, bus.mem_w_en}, {28'd0, exp_wen});
        chk("access_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("access_addr", {16'd0, bus.mem_address}, {16'd0, addr[15:0]});
        chk("access_wdata", bus.mem_write_data, wdata);
        @(posedge clk); #1;
        chk("resp_valid", {31'd0, bus.resp_valid}, 32'd1);
        chk("resp_rdata", bus.resp_rdata, exp_rdata);
        chk("resp_fault", {31'd0, bus.resp_fault}, {31'd0, exp_fault});
        chk("resp_wen", {28'd0, bus.mem_w_en}, 32'd0);
        for (int s = 0; s < stall; s++) begin
            if (s == stall - 1) bus.resp_ready = 1'b1;
            @(posedge clk); #1;
            if (s != stall - 1) begin
                chk("stall_valid", {31'd0, bus.resp_valid}, 32'd1);
                chk("stall_rdata", bus.resp_rdata, exp_rdata);
            end
        end
        if (stall == 0) begin
            @(posedge clk); #1;
        end
        chk("idle_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        chk({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
        chk({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
        chk({tag, "_resp_fault"}, {31'd0, bus.resp_fault}, 32'd0);
        chk({tag, "_wen"}, {28'd0, bus.mem_w_en}, 32'd0);
        chk({tag, "_addr"}, {16'd0, bus.mem_address}, 32'd0);
        chk({tag, "_wdata"}, bus.mem_write_data, 32'd0);
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
        logic [3:0]  wen;
    } vec_t;

    vec_t tbl [19];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] m_rdata;
        logic        m_fault;
        logic [3:0]  m_wen;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          r;

        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = 8'h00;

        tbl[0]  = '{1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 4'b1111};
        tbl[1]  = '{1'b0, 3'd2, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 4'b0000};
        tbl[2]  = '{1'b0, 3'd0, 32'h0000_0010, 32'h0,         32'hFFFF_FFEF, 1'b0, 4'b0000};
        tbl[3]  = '{1'b0, 3'd4, 32'h0000_0010, 32'h0,         32'h0000_00EF, 1'b0, 4'b0000};
        tbl[4]  = '{1'b0, 3'd1, 32'h0000_0012, 32'h0,         32'hFFFF_DEAD, 1'b0, 4'b0000};
        tbl[5]  = '{1'b0, 3'd5, 32'h0000_0012, 32'h0,         32'h0000_DEAD, 1'b0, 4'b0000};
        tbl[6]  = '{1'b1, 3'd0, 32'h0000_0011, 32'h1234_5677, 32'h0000_0000, 1'b0, 4'b0001};
        tbl[7]  = '{1'b1, 3'd1, 32'h0000_0020, 32'hAAAA_5555, 32'h0000_0000, 1'b0, 4'b0011};
        tbl[8]  = '{1'b0, 3'd2, 32'h0000_0010, 32'h0,         32'hDEAD_77EF, 1'b0, 4'b0000};
        tbl[9]  = '{1'b0, 3'd5, 32'h0000_0020, 32'h0,         32'h0000_5555, 1'b0, 4'b0000};
        tbl[10] = '{1'b1, 3'd2, 32'h0000_FFFD, 32'h0102_0304, 32'h0000_0000, 1'b1, 4'b0000};
        tbl[11] = '{1'b0, 3'd2, 32'h0000_FFFC, 32'h0,         32'h0000_0000, 1'b0, 4'b0000};
        tbl[12] = '{1'b0, 3'd0, 32'h0001_0000, 32'h0,         32'h0000_0000, 1'b1, 4'b0000};
        tbl[13] = '{1'b0, 3'd3, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1, 4'b0000};
        tbl[14] = '{1'b1, 3'd4, 32'h0000_0010, 32'h0000_0055, 32'h0000_0000, 1'b1, 4'b0000};
        tbl[15] = '{1'b1, 3'd1, 32'h0000_FFFE, 32'h1234_BEEF, 32'h0000_0000, 1'b0, 4'b0011};
        tbl[16] = '{1'b0, 3'd5, 32'h0000_FFFE, 32'h0,         32'h0000_BEEF, 1'b0, 4'b0000};
        tbl[17] = '{1'b0, 3'd1, 32'h0000_FFFF, 32'h0,         32'h0000_0000, 1'b1, 4'b0000};
        tbl[18] = '{1'b0, 3'd2, 32'h8000_0010, 32'h0,         32'h0000_0000, 1'b1, 4'b0000};

        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table; the model tracks memory contents for later phases.
        for (int i = 0; i < 19; i++) begin
            ref_txn(tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wdata, m_rdata, m_fault, m_wen);
            do_txn(tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                   tbl[i].rdata, tbl[i].fault, tbl[i].wen, 0);
        end

        // Backpressure: lw held 5 cycles while a new sb waits on req_valid.
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'd0;
        bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_store  = 1'b1;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'h50;
        bus.req_wdata  = 32'h0000_0099;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, bus.resp_valid}, 32'd1);
            chk("bp_rdata", bus.resp_rdata, 32'hDEAD_77EF);
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            chk("bp_wen", {28'd0, bus.mem_w_en}, 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("bp_next_wen", {28'd0, bus.mem_w_en}, 32'h1);
        chk("bp_next_addr", {16'd0, bus.mem_address}, 32'h50);
        @(posedge clk); #1;
        chk("bp_next_valid", {31'd0, bus.resp_valid}, 32'd1);
        chk("bp_next_fault", {31'd0, bus.resp_fault}, 32'd0);
        @(posedge clk); #1;
        ref_txn(1'b1, 3'd0, 32'h50, 32'h99, m_rdata, m_fault, m_wen);
        do_txn(1'b0, 3'd4, 32'h50, 32'h0, 32'h0000_0099, 1'b0, 4'b0000, 0);

        // Reset during the ACCESS cycle of sw 0x0040.
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h40;
        bus.req_wdata  = 32'h1122_3344;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("rstop_access_wen", {28'd0, bus.mem_w_en}, 32'hF);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("rstop");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstop_after_wen", {28'd0, bus.mem_w_en}, 32'd0);
        chk("rstop_after_valid", {31'd0, bus.resp_valid}, 32'd0);
        ref_txn(1'b1, 3'd2, 32'h40, 32'hA5A5_0F0F, m_rdata, m_fault, m_wen);
        do_txn(1'b1, 3'd2, 32'h40, 32'hA5A5_0F0F, m_rdata, m_fault, m_wen, 0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 200; n++) begin
            st    = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            wdata = $urandom;
            r     = int'($urandom_range(0, 99));
            if (r < 70)      addr = 32'($urandom_range(0, 255));
            else if (r < 90) addr = 32'h0000_FFF0 + 32'($urandom_range(0, 15));
            else             addr = $urandom;
            ref_txn(st, f3, addr, wdata, m_rdata, m_fault, m_wen);
            do_txn(st, f3, addr, wdata, m_rdata, m_fault, m_wen, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
